// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register offsets, source bit
// positions and the CPU vector assigned to each source.
package intc_pkg;

   localparam int unsigned INTC_NSRC = 7;
   localparam int unsigned INTC_VECW = 3;

   // Wishbone word offsets
   typedef enum logic [1:0] {
      INTC_PENDING = 2'd0,
      INTC_MASK    = 2'd1,
      INTC_MODE    = 2'd2,
      INTC_STATUS  = 2'd3
   } intc_reg_e;

   // Source bit positions
   localparam int unsigned SRC_MMU      = 6;
   localparam int unsigned SRC_TIMER3   = 5;
   localparam int unsigned SRC_TIMER2   = 4;
   localparam int unsigned SRC_TIMER1   = 3;
   localparam int unsigned SRC_TIMER0   = 2;
   localparam int unsigned SRC_UART0_RX = 1;
   localparam int unsigned SRC_UART0_TX = 0;

   // CPU vectors; 0 means no interrupt
   localparam logic [INTC_VECW-1:0] VEC_MMU      = 3'd1;
   localparam logic [INTC_VECW-1:0] VEC_TIMER0   = 3'd2;
   localparam logic [INTC_VECW-1:0] VEC_TIMER1   = 3'd3;
   localparam logic [INTC_VECW-1:0] VEC_TIMER2   = 3'd4;
   localparam logic [INTC_VECW-1:0] VEC_TIMER3   = 3'd5;
   localparam logic [INTC_VECW-1:0] VEC_UART0_RX = 3'd6;
   localparam logic [INTC_VECW-1:0] VEC_UART0_TX = 3'd7;

endpackage

// File: rtl/intcontroller_if.sv
// Wishbone slave bus for the interrupt controller register file.
//   master: drives cyc/stb/we/adr/sel/dat_i, receives dat_o/ack_o
//   slave : the controller side
interface intcontroller_if;
   logic        cyc_i;
   logic        stb_i;
   logic        we_i;
   logic [1:0]  adr_i;
   logic [3:0]  sel_i;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack_o;

   modport master (
      output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
      input  dat_o, ack_o
   );

   modport slave (
      input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
      output dat_o, ack_o
   );
endinterface

// File: rtl/intc_prio.sv
// Combinational priority encoder: highest set bit of active_i wins and is mapped
// to its CPU vector. Output is 0 when nothing is active.
//   active_i : pending & mask
//   vector_o : encoded vector
module intc_prio
   import intc_pkg::*;
#(
   parameter int unsigned NSRC = INTC_NSRC,
   parameter int unsigned VECW = INTC_VECW
) (
   input  logic [NSRC-1:0] active_i,
   output logic [VECW-1:0] vector_o
);

   always_comb begin
      vector_o = '0;
      if (active_i[SRC_MMU])           vector_o = VECW'(VEC_MMU);
      else if (active_i[SRC_TIMER3])   vector_o = VECW'(VEC_TIMER3);
      else if (active_i[SRC_TIMER2])   vector_o = VECW'(VEC_TIMER2);
      else if (active_i[SRC_TIMER1])   vector_o = VECW'(VEC_TIMER1);
      else if (active_i[SRC_TIMER0])   vector_o = VECW'(VEC_TIMER0);
      else if (active_i[SRC_UART0_RX]) vector_o = VECW'(VEC_UART0_RX);
      else if (active_i[SRC_UART0_TX]) vector_o = VECW'(VEC_UART0_TX);
   end

endmodule

// File: rtl/intcontroller.sv
// Interrupt controller for the bexkat2 CPU. Latches sources in edge or level
// mode, masks them, priority-encodes and presents a registered vector.
//   clk_i, reset_n : clock, async active-low reset
//   bus            : Wishbone slave (PENDING, MASK, MODE, STATUS)
//   src_i          : raw interrupt requests (synchronous)
//   int_en         : CPU global interrupt enable
//   cpu_interrupt  : vector to CPU, 0 = none
module intcontroller
   import intc_pkg::*;
#(
   parameter int unsigned NSRC = INTC_NSRC,
   parameter int unsigned VECW = INTC_VECW
) (
   input  logic            clk_i,
   input  logic            reset_n,
   intcontroller_if.slave  bus,
   input  logic [NSRC-1:0] src_i,
   input  logic            int_en,
   output logic [VECW-1:0] cpu_interrupt
);

   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic [NSRC-1:0] mode_q, mode_d;
   logic [NSRC-1:0] prev_q;
   logic [NSRC-1:0] clr;
   logic [NSRC-1:0] active;
   logic [VECW-1:0] vec;
   logic [VECW-1:0] cpu_q, cpu_d;
   logic            ack_q, ack_d;
   logic [31:0]     dat_q, dat_d;
   logic            access;
   logic            wr_lo;
   logic            unused_bits;

   // An access is the cycle in which ack is about to be registered high.
   assign access = bus.cyc_i & bus.stb_i & ~ack_q;
   assign wr_lo  = access & bus.we_i & bus.sel_i[0];
   assign active = pend_q & mask_q;

   intc_prio #(
      .NSRC (NSRC),
      .VECW (VECW)
   ) u_prio (
      .active_i (active),
      .vector_o (vec)
   );

   always_comb begin
      mask_d = mask_q;
      mode_d = mode_q;
      dat_d  = dat_q;
      ack_d  = access;
      clr    = '0;

      if (wr_lo) begin
         unique case (intc_reg_e'(bus.adr_i))
            INTC_PENDING: clr    = bus.dat_i[NSRC-1:0];
            INTC_MASK:    mask_d = bus.dat_i[NSRC-1:0];
            INTC_MODE:    mode_d = bus.dat_i[NSRC-1:0];
            INTC_STATUS:  ;
         endcase
      end

      // Edge bits: set beats W1C. Level bits: track the source directly.
      pend_d = (mode_q & ((pend_q & ~clr) | (src_i & ~prev_q))) | (~mode_q & src_i);

      if (access) begin
         dat_d = '0;
         unique case (intc_reg_e'(bus.adr_i))
            INTC_PENDING: dat_d[NSRC-1:0] = pend_q;
            INTC_MASK:    dat_d[NSRC-1:0] = mask_q;
            INTC_MODE:    dat_d[NSRC-1:0] = mode_q;
            INTC_STATUS: begin
               dat_d[8 +: NSRC]  = src_i;
               dat_d[VECW-1:0]   = cpu_q;
            end
         endcase
      end

      cpu_d = (int_en && (active != '0)) ? vec : '0;
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         pend_q <= '0;
         mask_q <= '0;
         mode_q <= '0;
         prev_q <= '0;
         cpu_q  <= '0;
         ack_q  <= 1'b0;
         dat_q  <= '0;
      end else begin
         pend_q <= pend_d;
         mask_q <= mask_d;
         mode_q <= mode_d;
         prev_q <= src_i;
         cpu_q  <= cpu_d;
         ack_q  <= ack_d;
         dat_q  <= dat_d;
      end
   end

   assign bus.ack_o     = ack_q;
   assign bus.dat_o     = dat_q;
   assign cpu_interrupt = cpu_q;

   // Upper write bytes are read-only zero.
   assign unused_bits = ^{bus.dat_i[31:NSRC], bus.sel_i[3:1]};

endmodule

// File: tb/tb_intcontroller.sv
module tb_intcontroller;
   import intc_pkg::*;

   logic       clk_i = 1'b0;
   logic       reset_n;
   logic [6:0] src_i;
   logic       int_en;
   logic [2:0] cpu_interrupt;
   int         n_cmp = 0;
   int         n_fail = 0;

   intcontroller_if bus ();

   intcontroller dut (
      .clk_i         (clk_i),
      .reset_n       (reset_n),
      .bus           (bus.slave),
      .src_i         (src_i),
      .int_en        (int_en),
      .cpu_interrupt (cpu_interrupt)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [6:0] mask;
      logic [6:0] src;
      logic       en;
      logic [2:0] exp;
   } vec_t;

   vec_t tbl [13];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic wb_access(input logic we, input logic [1:0] adr, input logic [31:0] d,
                            input logic [3:0] sel, output logic [31:0] rd);
      logic got;
      bus.cyc_i = 1'b1;
      bus.stb_i = 1'b1;
      bus.we_i  = we;
      bus.adr_i = adr;
      bus.dat_i = d;
      bus.sel_i = sel;
      got = 1'b0;
      rd  = '0;
      for (int k = 0; k < 4 && !got; k++) begin
         tick();
         got = bus.ack_o;
      end
      if (!got) begin
         n_cmp++;
         n_fail++;
         $display("FAIL ack_timeout: got no ack, want ack within 4 cycles");
      end
      rd = bus.dat_o;
      bus.cyc_i = 1'b0;
      bus.stb_i = 1'b0;
      bus.we_i  = 1'b0;
      tick();
   endtask

   task automatic wb_write(input logic [1:0] adr, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] dummy;
      wb_access(1'b1, adr, d, sel, dummy);
   endtask

   task automatic wb_read(input logic [1:0] adr, output logic [31:0] rd);
      wb_access(1'b0, adr, 32'h0, 4'hF, rd);
   endtask

   logic [31:0] rd;

   initial begin
      tbl[0]  = '{7'h7F, 7'h7F, 1'b1, 3'd1};
      tbl[1]  = '{7'h7F, 7'h3F, 1'b1, 3'd5};
      tbl[2]  = '{7'h7F, 7'h1F, 1'b1, 3'd4};
      tbl[3]  = '{7'h7F, 7'h0F, 1'b1, 3'd3};
      tbl[4]  = '{7'h7F, 7'h07, 1'b1, 3'd2};
      tbl[5]  = '{7'h7F, 7'h03, 1'b1, 3'd6};
      tbl[6]  = '{7'h7F, 7'h01, 1'b1, 3'd7};
      tbl[7]  = '{7'h7F, 7'h00, 1'b1, 3'd0};
      tbl[8]  = '{7'h7F, 7'h7F, 1'b0, 3'd0};
      tbl[9]  = '{7'h00, 7'h7F, 1'b1, 3'd0};
      tbl[10] = '{7'h20, 7'h7F, 1'b1, 3'd5};
      tbl[11] = '{7'h05, 7'h7F, 1'b1, 3'd2};
      tbl[12] = '{7'h41, 7'h41, 1'b1, 3'd1};

      reset_n   = 1'b0;
      src_i     = '0;
      int_en    = 1'b0;
      bus.cyc_i = 1'b0;
      bus.stb_i = 1'b0;
      bus.we_i  = 1'b0;
      bus.adr_i = '0;
      bus.sel_i = '0;
      bus.dat_i = '0;

      // Reset state
      #12;
      check("rst_ack", 32'(bus.ack_o), 32'h0);
      check("rst_dat", bus.dat_o, 32'h0);
      check("rst_cpu", 32'(cpu_interrupt), 32'h0);
      reset_n = 1'b1;
      tick();
      wb_read(INTC_PENDING, rd); check("rst_pending", rd, 32'h0);
      wb_read(INTC_MASK, rd);    check("rst_mask", rd, 32'h0);
      wb_read(INTC_MODE, rd);    check("rst_mode", rd, 32'h0);
      src_i = 7'h2A;
      tick();
      wb_read(INTC_STATUS, rd);  check("rst_status", rd, 32'h0000_2A00);
      src_i = '0;

      // Held strobe: ack every second cycle
      bus.cyc_i = 1'b1;
      bus.stb_i = 1'b1;
      bus.adr_i = 2'd1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("held_ack", 32'(bus.ack_o), (k % 2 == 0) ? 32'h1 : 32'h0);
      end
      bus.cyc_i = 1'b0;
      bus.stb_i = 1'b0;
      tick();

      // Level source latency
      wb_write(INTC_MASK, 32'h04, 4'h1);
      int_en = 1'b1;
      src_i  = 7'h04;
      tick(); check("lvl_n1", 32'(cpu_interrupt), 32'h0);
      tick(); check("lvl_n2", 32'(cpu_interrupt), 32'h2);
      src_i = '0;
      tick(); check("lvl_fall_m1", 32'(cpu_interrupt), 32'h2);
      tick(); check("lvl_fall_m2", 32'(cpu_interrupt), 32'h0);
      src_i = 7'h04;
      tick(); tick();
      wb_write(INTC_PENDING, 32'h04, 4'h1);
      check("lvl_w1c_cpu", 32'(cpu_interrupt), 32'h2);
      wb_read(INTC_PENDING, rd); check("lvl_w1c_pend", rd, 32'h04);
      src_i = '0;
      tick(); tick();

      // Edge source
      wb_write(INTC_MODE, 32'h03, 4'h1);
      wb_write(INTC_MASK, 32'h03, 4'h1);
      src_i = 7'h02;
      tick();
      src_i = '0;
      tick(); check("edge_vec", 32'(cpu_interrupt), 32'h6);
      tick(); tick(); tick();
      check("edge_hold", 32'(cpu_interrupt), 32'h6);
      wb_read(INTC_PENDING, rd); check("edge_pend", rd, 32'h02);
      wb_write(INTC_PENDING, 32'h02, 4'h1);
      check("edge_w1c_cpu", 32'(cpu_interrupt), 32'h0);
      wb_read(INTC_PENDING, rd); check("edge_w1c_pend", rd, 32'h0);
      src_i = 7'h02;  // rising edge lands on the same clock as the W1C
      wb_write(INTC_PENDING, 32'h02, 4'h1);
      src_i = '0;
      check("edge_set_wins_cpu", 32'(cpu_interrupt), 32'h6);
      wb_read(INTC_PENDING, rd); check("edge_set_wins_pend", rd, 32'h02);
      wb_write(INTC_PENDING, 32'h02, 4'h1);

      // Masking
      wb_write(INTC_MODE, 32'h00, 4'h1);
      wb_write(INTC_MASK, 32'h00, 4'h1);
      src_i = 7'h20;
      tick(); tick();
      check("mask_off", 32'(cpu_interrupt), 32'h0);
      wb_write(INTC_MASK, 32'h20, 4'h1);
      check("mask_on", 32'(cpu_interrupt), 32'h5);
      wb_write(INTC_MASK, 32'h00, 4'hE);
      wb_read(INTC_MASK, rd); check("mask_sel_hi", rd, 32'h20);
      check("mask_sel_cpu", 32'(cpu_interrupt), 32'h5);

      // Priority / enable table
      for (int i = 0; i < 13; i++) begin
         src_i  = tbl[i].src;
         int_en = tbl[i].en;
         wb_write(INTC_MASK, 32'(tbl[i].mask), 4'h1);
         tick(); tick();
         check($sformatf("tbl[%0d]", i), 32'(cpu_interrupt), 32'(tbl[i].exp));
      end

      // Async reset mid-read
      src_i = '0;
      wb_write(INTC_MODE, 32'h02, 4'h1);
      src_i = 7'h02;
      tick();
      src_i = 7'h08;
      wb_write(INTC_MASK, 32'h08, 4'h1);
      int_en = 1'b1;
      tick(); tick();
      check("pre_rst_cpu", 32'(cpu_interrupt), 32'h3);
      bus.cyc_i = 1'b1;
      bus.stb_i = 1'b1;
      bus.we_i  = 1'b0;
      bus.adr_i = INTC_STATUS;
      src_i = '0;
      tick();
      check("pre_rst_ack", 32'(bus.ack_o), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check("async_ack", 32'(bus.ack_o), 32'h0);
      check("async_cpu", 32'(cpu_interrupt), 32'h0);
      bus.cyc_i = 1'b0;
      bus.stb_i = 1'b0;
      #1 reset_n = 1'b1;
      tick();
      wb_read(INTC_MODE, rd);    check("post_rst_mode", rd, 32'h0);
      wb_read(INTC_PENDING, rd); check("post_rst_pend", rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, want finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
